// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, threshold flags, sticky error flags
// and a selectable registered or first-word-fall-through read port.
module sync_fifo_flags #(
  parameter int DSIZE         = 8,
  parameter int ASIZE         = 4,
  parameter int AFULL_MARGIN  = 2,
  parameter int AEMPTY_MARGIN = 2,
  parameter bit FWFT          = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             winc,
  input  logic [DSIZE-1:0] wdata,
  input  logic             rinc,
  input  logic             clr_err,
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             walmost_full,
  output logic             ralmost_empty,
  output logic [ASIZE:0]   count,
  output logic             overflow,
  output logic             underflow
);

  localparam int DEPTH = 1 << ASIZE;
  localparam int CW    = ASIZE + 1;
  localparam logic [ASIZE:0] DEPTH_LVL  = CW'(DEPTH);
  localparam logic [ASIZE:0] AFULL_LVL  = CW'(DEPTH - AFULL_MARGIN);
  localparam logic [ASIZE:0] AEMPTY_LVL = CW'(AEMPTY_MARGIN);

  logic [DSIZE-1:0] mem [DEPTH];
  logic [ASIZE:0]   wptr;
  logic [ASIZE:0]   rptr;
  logic             wr_en;
  logic             rd_en;

  // Flags come only from the pointer registers; requests never feed them.
  assign count         = wptr - rptr;
  assign wfull         = (count == DEPTH_LVL);
  assign rempty        = (count == '0);
  assign walmost_full  = (count >= AFULL_LVL);
  assign ralmost_empty = (count <= AEMPTY_LVL);

  assign wr_en = winc && !wfull;
  assign rd_en = rinc && !rempty;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[ASIZE-1:0]] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
    end
  end

  // A new error in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (winc && wfull)  overflow <= 1'b1;
      else if (clr_err)   overflow <= 1'b0;
      if (rinc && rempty) underflow <= 1'b1;
      else if (clr_err)   underflow <= 1'b0;
    end
  end

  generate
    if (FWFT) begin : g_fwft
      assign rdata = mem[rptr[ASIZE-1:0]];
    end else begin : g_reg
      logic [DSIZE-1:0] rdata_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst)        rdata_q <= '0;
        else if (rd_en) rdata_q <= mem[rptr[ASIZE-1:0]];
      end
      assign rdata = rdata_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags: registered-read instance for the main
// flows plus a small FWFT instance for fall-through timing.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       winc = 1'b0, rinc = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;
  logic [7:0] rdata;
  logic       wfull, rempty, walmost_full, ralmost_empty, overflow, underflow;
  logic [4:0] count;

  logic       f_winc = 1'b0, f_rinc = 1'b0;
  logic [7:0] f_rdata;
  logic       f_wfull, f_rempty, f_walmost_full, f_ralmost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q [$];
  logic [7:0] exp_v;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_MARGIN(2), .AEMPTY_MARGIN(2), .FWFT(1'b0)) u_dut (
    .clk(clk), .rst(rst), .winc(winc), .wdata(wdata), .rinc(rinc), .clr_err(clr_err),
    .rdata(rdata), .wfull(wfull), .rempty(rempty), .walmost_full(walmost_full),
    .ralmost_empty(ralmost_empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  sync_fifo_flags #(.DSIZE(8), .ASIZE(4), .AFULL_MARGIN(2), .AEMPTY_MARGIN(2), .FWFT(1'b1)) u_fwft (
    .clk(clk), .rst(rst), .winc(f_winc), .wdata(wdata), .rinc(f_rinc), .clr_err(clr_err),
    .rdata(f_rdata), .wfull(f_wfull), .rempty(f_rempty), .walmost_full(f_walmost_full),
    .ralmost_empty(f_ralmost_empty), .count(f_count), .overflow(f_overflow), .underflow(f_underflow)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    winc = 1'b0; rinc = 1'b0; clr_err = 1'b0;
    f_winc = 1'b0; f_rinc = 1'b0;
  endtask

  initial begin
    #2;
    check("rst_count", count, 0);
    check("rst_rempty", rempty, 1);
    check("rst_ralmost_empty", ralmost_empty, 1);
    check("rst_wfull", wfull, 0);
    check("rst_walmost_full", walmost_full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_underflow", underflow, 0);
    check("rst_rdata", rdata, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // FWFT: head word visible as soon as rempty falls
    f_winc = 1'b1; wdata = 8'hA5;
    tick();
    idle();
    check("fwft_rempty_fall", f_rempty, 0);
    check("fwft_rdata", f_rdata, 8'hA5);
    f_rinc = 1'b1;
    tick();
    idle();
    check("fwft_rempty_rise", f_rempty, 1);

    // fill 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      winc = 1'b1; wdata = 8'(i);
      tick();
      check("fill_count", count, i + 1);
      check("fill_walmost_full", walmost_full, (i + 1 >= 14) ? 1 : 0);
      check("fill_ralmost_empty", ralmost_empty, (i + 1 <= 2) ? 1 : 0);
    end
    check("fill_wfull", wfull, 1);

    // overflow while full
    winc = 1'b1; wdata = 8'hFF;
    tick();
    idle();
    check("ovf_set", overflow, 1);
    check("ovf_count", count, 16);
    tick();
    check("ovf_sticky", overflow, 1);
    clr_err = 1'b1;
    tick();
    idle();
    check("ovf_clr", overflow, 0);

    // read+write at full: only the read is accepted
    winc = 1'b1; rinc = 1'b1; wdata = 8'hEE;
    tick();
    idle();
    check("full_rw_count", count, 15);
    check("full_rw_overflow", overflow, 1);
    check("full_rw_rdata", rdata, 8'h00);
    clr_err = 1'b1;
    tick();
    idle();

    // drain the rest in order
    for (int i = 1; i < 16; i++) begin
      rinc = 1'b1;
      tick();
      check("drain_rdata", rdata, i);
    end
    idle();
    check("drain_rempty", rempty, 1);
    check("drain_count", count, 0);
    check("drain_wfull", wfull, 0);

    // underflow while empty, set beats clear
    rinc = 1'b1;
    tick();
    check("udf_set", underflow, 1);
    check("udf_count", count, 0);
    check("udf_rdata_hold", rdata, 8'h0F);
    clr_err = 1'b1;
    tick();
    check("udf_set_wins", underflow, 1);
    rinc = 1'b0;
    tick();
    idle();
    check("udf_clr", underflow, 0);

    // read+write at empty: only the write is accepted
    winc = 1'b1; rinc = 1'b1; wdata = 8'h77;
    tick();
    idle();
    check("empty_rw_count", count, 1);
    check("empty_rw_underflow", underflow, 1);
    check("empty_rw_rdata", rdata, 8'h0F);
    clr_err = 1'b1;
    tick();
    idle();
    rinc = 1'b1;
    tick();
    idle();
    check("empty_rw_data", rdata, 8'h77);
    check("empty_rw_drained", count, 0);

    // read+write at count 5
    for (int i = 0; i < 5; i++) begin
      winc = 1'b1; wdata = 8'h10 + 8'(i);
      exp_q.push_back(wdata);
      tick();
    end
    winc = 1'b1; rinc = 1'b1; wdata = 8'h15;
    exp_q.push_back(wdata);
    tick();
    idle();
    exp_v = exp_q.pop_front();
    check("c5_count", count, 5);
    check("c5_rdata", rdata, exp_v);
    for (int i = 0; i < 2; i++) begin
      rinc = 1'b1;
      tick();
      exp_v = exp_q.pop_front();
      check("c5_order", rdata, exp_v);
    end
    idle();
    check("c3_count", count, 3);

    // 40 write/read pairs at count 3 to wrap both pointers
    for (int i = 0; i < 40; i++) begin
      winc = 1'b1; rinc = 1'b1; wdata = 8'h80 + 8'(i);
      exp_q.push_back(wdata);
      tick();
      exp_v = exp_q.pop_front();
      check("wrap_rdata", rdata, exp_v);
      check("wrap_count", count, 3);
      check("wrap_flags", {wfull, rempty}, 2'b00);
    end
    idle();

    // bring count to 9 then reset between edges
    for (int i = 0; i < 6; i++) begin
      winc = 1'b1; wdata = 8'hC0 + 8'(i);
      tick();
    end
    idle();
    check("pre_rst_count", count, 9);
    #3 rst = 1'b1;
    #1;
    check("arst_count", count, 0);
    check("arst_rempty", rempty, 1);
    check("arst_ralmost_empty", ralmost_empty, 1);
    check("arst_wfull", wfull, 0);
    check("arst_walmost_full", walmost_full, 0);
    check("arst_rdata", rdata, 0);
    #1 rst = 1'b0;
    exp_q.delete();
    tick();
    winc = 1'b1; wdata = 8'h5A;
    tick();
    idle();
    check("post_rst_count", count, 1);
    rinc = 1'b1;
    tick();
    idle();
    check("post_rst_rdata", rdata, 8'h5A);
    check("post_rst_rempty", rempty, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
